// File: rtl/lock_ctrl_pkg.sv
// Shared types and constants for the door-lock motion controller.
package lock_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    OPENING   = 3'd1,
    OPEN_HOLD = 3'd2,
    CLOSING   = 3'd3,
    LOCKOUT   = 3'd4
  } lock_state_t;

  localparam logic DIR_OPEN  = 1'b1;
  localparam logic DIR_CLOSE = 1'b0;

  // Bolt is in motion or being held open.
  function automatic logic state_is_busy(lock_state_t s);
    return (s == OPENING) || (s == OPEN_HOLD) || (s == CLOSING);
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Free-running STEP_DIV clock divider producing a one-cycle step tick.
module step_tick_gen #(
  parameter int unsigned STEP_DIV = 20000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DivW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(STEP_DIV - 1);

  logic [DivW-1:0] div_q;

  // Divider counts 0..STEP_DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else if (div_q == DivLast) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick = (div_q == DivLast);

endmodule

// File: rtl/lock_motion_ctrl.sv
// Door-lock bolt sequencer: opens on a good code, holds, closes; locks out after
// repeated bad codes. Issues step_pulse/step_dir only.
// Optional feature: define LOCK_OBSTRUCT_EN to make obstruct reopen/hold the bolt.
module lock_motion_ctrl #(
  parameter int unsigned STEP_DIV      = 20000,
  parameter int unsigned OPEN_STEPS    = 100,
  parameter int unsigned HOLD_TICKS    = 500,
  parameter int unsigned MAX_FAIL      = 3,
  parameter int unsigned LOCKOUT_TICKS = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic code_valid,
  input  logic match,
  input  logic obstruct,
  output logic step_pulse,
  output logic step_dir,
  output logic busy,
  output logic is_open,
  output logic alarm
);

  import lock_ctrl_pkg::*;

  localparam int unsigned StepW  = $clog2(OPEN_STEPS + 1);
  localparam int unsigned TimMax = (HOLD_TICKS > LOCKOUT_TICKS) ? HOLD_TICKS : LOCKOUT_TICKS;
  localparam int unsigned TimW   = $clog2(TimMax + 1);
  localparam int unsigned FailW  = $clog2(MAX_FAIL + 1);

  localparam logic [StepW-1:0] OpenStepsC    = StepW'(OPEN_STEPS);
  localparam logic [StepW-1:0] StepOneC      = StepW'(1);
  localparam logic [TimW-1:0]  HoldTicksC    = TimW'(HOLD_TICKS);
  localparam logic [TimW-1:0]  LockoutTicksC = TimW'(LOCKOUT_TICKS);
  localparam logic [FailW-1:0] MaxFailC      = FailW'(MAX_FAIL);

  lock_state_t      state_q, state_d;
  logic [StepW-1:0] step_cnt_q, step_cnt_d;
  logic [TimW-1:0]  tim_cnt_q, tim_cnt_d;   // hold ticks or lockout ticks
  logic [FailW-1:0] fail_cnt_q, fail_cnt_d;
  logic             step_pulse_q, step_pulse_d;
  logic             step_dir_q, step_dir_d;

  logic tick;
  logic good_code;
  logic bad_code;
  logic reopen;
  logic [StepW-1:0] step_inc;
  logic [TimW-1:0]  tim_inc;
  logic [FailW-1:0] fail_inc;

  step_tick_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

`ifdef LOCK_OBSTRUCT_EN
  assign reopen = obstruct;
`else
  logic obstruct_unused;
  assign obstruct_unused = obstruct;
  assign reopen          = 1'b0;
`endif

  assign good_code = code_valid & match;
  assign bad_code  = code_valid & ~match;
  assign step_inc  = step_cnt_q + 1'b1;
  assign tim_inc   = tim_cnt_q + 1'b1;
  assign fail_inc  = fail_cnt_q + 1'b1;

  // Next-state logic: a code decision pre-empts any tick on the same clk.
  always_comb begin
    state_d      = state_q;
    step_cnt_d   = step_cnt_q;
    tim_cnt_d    = tim_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    step_pulse_d = 1'b0;
    step_dir_d   = step_dir_q;

    unique case (state_q)
      IDLE: begin
        if (good_code) begin
          fail_cnt_d = '0;
          state_d    = OPENING;
        end else if (bad_code) begin
          fail_cnt_d = fail_inc;
          if (fail_inc == MaxFailC) begin
            tim_cnt_d = '0;
            state_d   = LOCKOUT;
          end
        end
      end

      OPENING: begin
        // A resume from CLOSING before any close step is already fully open.
        if (step_cnt_q == OpenStepsC) begin
          tim_cnt_d = '0;
          state_d   = OPEN_HOLD;
        end else if (tick) begin
          step_pulse_d = 1'b1;
          step_dir_d   = DIR_OPEN;
          step_cnt_d   = step_inc;
          if (step_inc == OpenStepsC) begin
            tim_cnt_d = '0;
            state_d   = OPEN_HOLD;
          end
        end
      end

      OPEN_HOLD: begin
        if (good_code || reopen) begin
          tim_cnt_d = '0;
        end else if (tick) begin
          tim_cnt_d = tim_inc;
          if (tim_inc == HoldTicksC) begin
            state_d = CLOSING;
          end
        end
      end

      CLOSING: begin
        if (good_code || reopen) begin
          state_d = OPENING;
        end else if (tick) begin
          step_pulse_d = 1'b1;
          step_dir_d   = DIR_CLOSE;
          step_cnt_d   = step_cnt_q - 1'b1;
          if (step_cnt_q == StepOneC) begin
            state_d = IDLE;
          end
        end
      end

      LOCKOUT: begin
        if (tick) begin
          tim_cnt_d = tim_inc;
          if (tim_inc == LockoutTicksC) begin
            fail_cnt_d = '0;
            state_d    = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers; reset treats the bolt as closed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      step_cnt_q   <= '0;
      tim_cnt_q    <= '0;
      fail_cnt_q   <= '0;
      step_pulse_q <= 1'b0;
      step_dir_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_cnt_q   <= step_cnt_d;
      tim_cnt_q    <= tim_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      step_pulse_q <= step_pulse_d;
      step_dir_q   <= step_dir_d;
    end
  end

  assign step_pulse = step_pulse_q;
  assign step_dir   = step_dir_q;
  assign busy       = state_is_busy(state_q);
  assign is_open    = (state_q == OPEN_HOLD);
  assign alarm      = (state_q == LOCKOUT);

endmodule

// File: tb/tb_lock_motion_ctrl.sv
// Bench for lock_motion_ctrl: vector table, directed corner sequences and a
// randomized run, all checked against a behavioural model of the lock.
module tb_lock_motion_ctrl;

  localparam int SD = 4;
  localparam int OS = 5;
  localparam int HT = 3;
  localparam int MF = 3;
  localparam int LT = 6;

`ifdef LOCK_OBSTRUCT_EN
  localparam bit ObsEn = 1'b1;
`else
  localparam bit ObsEn = 1'b0;
`endif

  // Model modes
  localparam int MIdle = 0;
  localparam int MOpening = 1;
  localparam int MHold = 2;
  localparam int MClosing = 3;
  localparam int MLock = 4;

  logic clk = 1'b0;
  logic reset, code_valid, match, obstruct;
  logic step_pulse, step_dir, busy, is_open, alarm;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_mode, m_pos, m_fails, m_timer, m_cyc;
  bit m_pulse, m_dir, m_last_tick;

  always #5 clk = ~clk;

  lock_motion_ctrl #(
    .STEP_DIV      (SD),
    .OPEN_STEPS    (OS),
    .HOLD_TICKS    (HT),
    .MAX_FAIL      (MF),
    .LOCKOUT_TICKS (LT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .match      (match),
    .obstruct   (obstruct),
    .step_pulse (step_pulse),
    .step_dir   (step_dir),
    .busy       (busy),
    .is_open    (is_open),
    .alarm      (alarm)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the lock as described by its rules.
  task automatic model_edge(input bit cv, input bit m, input bit ob, input bit rst);
    bit tick, good, bad, reop;
    if (rst) begin
      m_mode = MIdle; m_pos = 0; m_fails = 0; m_timer = 0; m_cyc = 0;
      m_pulse = 0; m_dir = 0; m_last_tick = 0;
      return;
    end
    tick = (m_cyc % SD) == SD - 1;
    m_last_tick = tick;
    m_cyc++;
    good = cv && m;
    bad = cv && !m;
    reop = ObsEn && ob;
    m_pulse = 0;
    case (m_mode)
      MIdle: begin
        if (good) begin
          m_fails = 0; m_mode = MOpening;
        end else if (bad) begin
          m_fails++;
          if (m_fails == MF) begin m_mode = MLock; m_timer = 0; end
        end
      end
      MOpening: begin
        if (m_pos >= OS) begin
          m_mode = MHold; m_timer = 0;
        end else if (tick) begin
          m_pulse = 1; m_dir = 1; m_pos++;
          if (m_pos == OS) begin m_mode = MHold; m_timer = 0; end
        end
      end
      MHold: begin
        if (good || reop) m_timer = 0;
        else if (tick) begin
          m_timer++;
          if (m_timer == HT) m_mode = MClosing;
        end
      end
      MClosing: begin
        if (good || reop) m_mode = MOpening;
        else if (tick) begin
          m_pulse = 1; m_dir = 0; m_pos--;
          if (m_pos == 0) m_mode = MIdle;
        end
      end
      default: begin
        if (tick) begin
          m_timer++;
          if (m_timer == LT) begin m_fails = 0; m_mode = MIdle; end
        end
      end
    endcase
  endtask

  task automatic check_model();
    logic [4:0] exp;
    exp = {m_pulse, m_dir, (m_mode >= MOpening && m_mode <= MClosing),
           (m_mode == MHold), (m_mode == MLock)};
    cmp("cycle {pulse,dir,busy,open,alarm}", 32'({step_pulse, step_dir, busy, is_open, alarm}),
        32'(exp));
  endtask

  // Apply inputs for one clock, advance the model, compare on the falling edge.
  task automatic drive(input bit cv, input bit m, input bit ob, input bit rst);
    code_valid = cv; match = m; obstruct = ob; reset = rst;
    @(posedge clk);
    model_edge(cv, m, ob, rst);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy || alarm) && n < bound) begin
      drive(0, 0, 0, 0);
      n++;
    end
    cmp("wait for idle timeout", 32'(busy | alarm), 32'd0);
  endtask

  typedef struct {
    string name;
    bit cv;
    bit m;
    int idle_n;
    logic [2:0] exp; // {busy, is_open, alarm}
  } vec_t;

  vec_t tbl[12];

  initial begin
    int n, pulses, open_pulses, ticks;

    reset = 1; code_valid = 0; match = 0; obstruct = 0;
    @(negedge clk);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    cmp("reset outputs", 32'({step_pulse, step_dir, busy, is_open, alarm}), 32'd0);

    // Cycle numbers in comments count clock edges after reset release.
    tbl[0]  = '{"good code starts opening", 1, 1, 0,  3'b100};  // 1
    tbl[1]  = '{"fifth open step to hold", 0, 0, 18, 3'b110};   // 20
    tbl[2]  = '{"third hold tick closes",  0, 0, 11, 3'b100};   // 32
    tbl[3]  = '{"still closing",           0, 0, 18, 3'b100};   // 51
    tbl[4]  = '{"fifth close step idle",   0, 0, 0,  3'b000};   // 52
    tbl[5]  = '{"bad code 1",              1, 0, 0,  3'b000};   // 53
    tbl[6]  = '{"bad code 2",              1, 0, 0,  3'b000};   // 54
    tbl[7]  = '{"bad code 3 lockout",      1, 0, 0,  3'b001};   // 55
    tbl[8]  = '{"good code in lockout",    1, 1, 0,  3'b001};   // 56
    tbl[9]  = '{"lockout tick 5",          0, 0, 18, 3'b001};   // 75
    tbl[10] = '{"lockout tick 6 exits",    0, 0, 0,  3'b000};   // 76
    tbl[11] = '{"good code after lockout", 1, 1, 0,  3'b100};   // 77
    foreach (tbl[i]) begin
      drive(tbl[i].cv, tbl[i].m, 0, 0);
      idle(tbl[i].idle_n);
      cmp(tbl[i].name, 32'({busy, is_open, alarm}), 32'(tbl[i].exp));
    end

    // Reset while opening: closed and silent from the next clock on.
    idle(3);
    drive(0, 0, 0, 1);
    cmp("reset in opening", 32'({step_pulse, step_dir, busy, is_open, alarm}), 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 0);
      if (step_pulse) pulses++;
    end
    cmp("pulses after reset", 32'(pulses), 32'd0);

    // Two bad, one good, two bad: the good code clears the fail count.
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    wait_idle(200);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    cmp("no lockout after cleared fails", 32'(alarm), 32'd0);
    drive(1, 0, 0, 0);
    cmp("third bad code locks out", 32'(alarm), 32'd1);
    wait_idle(100);

    // Good code after the second close step resumes opening from there.
    drive(1, 1, 0, 0);
    pulses = 0;
    n = 0;
    while (pulses < 2 && n < 200) begin
      drive(0, 0, 0, 0);
      if (step_pulse && !step_dir) pulses++;
      n++;
    end
    cmp("two close steps seen", 32'(pulses), 32'd2);
    drive(1, 1, 0, 0);
    pulses = 0; open_pulses = 0; n = 0;
    while (!is_open && n < 100) begin
      drive(0, 0, 0, 0);
      if (step_pulse) pulses++;
      if (step_pulse && step_dir) open_pulses++;
      n++;
    end
    cmp("reopen pulses total", 32'(pulses), 32'd2);
    cmp("reopen pulses with dir open", 32'(open_pulses), 32'd2);

    // Good code at hold tick 2 restarts the hold.
    n = 0;
    while (m_timer != 2 && n < 50) begin
      drive(0, 0, 0, 0);
      n++;
    end
    cmp("reached hold tick 2", 32'({is_open, 1'b0}) | 32'(m_timer), 32'h2 | 32'h2);
    drive(1, 1, 0, 0);
    ticks = 0; n = 0;
    while (is_open && n < 100) begin
      drive(0, 0, 0, 0);
      if (m_last_tick) ticks++;
      n++;
    end
    cmp("hold ticks after restart", 32'(ticks), 32'd3);
    cmp("closing after restarted hold", 32'({busy, is_open}), 32'b10);

    // Obstruct during closing.
    drive(0, 0, 1, 0);
    n = 0;
    while (!step_pulse && n < 20) begin
      drive(0, 0, 0, 0);
      n++;
    end
    cmp("step after obstruct seen", 32'(step_pulse), 32'd1);
    cmp("dir after obstruct", 32'(step_dir), 32'(ObsEn));
    wait_idle(300);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom % 16) == 0, $urandom % 2, ($urandom % 25) == 0, ($urandom % 600) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
